// File: rtl/cpu_press_gen_if.sv
// Bundle between the game core and the computer-opponent press generator.
// The core drives enable, rand_in and threshold; the generator drives press and cooling.
interface cpu_press_gen_if #(
  parameter int W = 10
);
  logic         enable;
  logic [W-1:0] rand_in;
  logic [W-2:0] threshold;
  logic         press;
  logic         cooling;

  modport master (
    output enable,
    output rand_in,
    output threshold,
    input  press,
    input  cooling
  );

  modport slave (
    input  enable,
    input  rand_in,
    input  threshold,
    output press,
    output cooling
  );
endinterface

// File: rtl/cpu_press_gen.sv
// Computer-opponent press generator: one random hit test per tick,
// a one-cycle press pulse, then a tick-counted cooldown.
module cpu_press_gen #(
  parameter int W        = 10,
  parameter int TICK_DIV = 1024,
  parameter int COOLDOWN = 4
) (
  input  logic            clk,
  input  logic            reset,
  cpu_press_gen_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);
  localparam logic [CW-1:0] COOL_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FIRE,
    COOL
  } state_t;

  state_t        state;
  state_t        next;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] cool_cnt;
  logic [CW-1:0] cool_nxt;
  logic [W-1:0]  thr_ext;
  logic          tick;
  logic          hit;

  assign thr_ext = {1'b0, bus.threshold};
  assign tick    = bus.enable && (tick_cnt == TICK_LAST);
  assign hit     = thr_ext > bus.rand_in;

  always_comb begin
    next     = state;
    cool_nxt = cool_cnt;
    if (!bus.enable) begin
      next     = IDLE;
      cool_nxt = '0;
    end else begin
      unique case (state)
        IDLE: next = ARMED;
        ARMED: begin
          if (tick && hit) next = FIRE;
        end
        FIRE: begin
          if (COOLDOWN == 0) begin
            next = ARMED;
          end else begin
            next     = COOL;
            cool_nxt = COOL_LOAD;
          end
        end
        COOL: begin
          // the hit test is deliberately skipped here
          if (tick) begin
            cool_nxt = cool_cnt - COOL_ONE;
            if (cool_cnt == COOL_ONE) next = ARMED;
          end
        end
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!bus.enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cool_cnt    <= '0;
      bus.press   <= 1'b0;
      bus.cooling <= 1'b0;
    end else begin
      state       <= next;
      cool_cnt    <= cool_nxt;
      bus.press   <= (next == FIRE);
      bus.cooling <= (next == COOL);
    end
  end

endmodule

// File: tb/tb_cpu_press_gen.sv
// Directed bench: per-cycle vector table on a COOLDOWN=2 instance,
// plus hand sequences for COOLDOWN=0 spacing and reset during a pulse.
module tb_cpu_press_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_press_gen_if #(.W(10)) ia ();
  cpu_press_gen_if #(.W(10)) ib ();

  cpu_press_gen #(
    .W(10), .TICK_DIV(4), .COOLDOWN(2)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );

  cpu_press_gen #(
    .W(10), .TICK_DIV(4), .COOLDOWN(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  typedef struct {
    logic       en;
    logic [9:0] rnd;
    logic [8:0] thr;
    logic       exp_press;
    logic       exp_cool;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic en, input logic [9:0] rnd,
                              input logic [8:0] thr, input logic ep,
                              input logic ec);
    vec_t v;
    v.en        = en;
    v.rnd       = rnd;
    v.thr       = thr;
    v.exp_press = ep;
    v.exp_cool  = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    bit seen;

    // drop enable to restart from IDLE with a fresh tick count
    add(1'b0, 10'h0FF, 9'h100, 1'b0, 1'b0);
    // basic fire: tick c3, press c4, cool c5..c11, press c16, cool c17
    for (int i = 0; i < 18; i++)
      add(1'b1, 10'h0FF, 9'h100, (i == 4) || (i == 16),
          ((i >= 5) && (i <= 11)) || (i == 17));
    // enable dropped while cooling: cooling still up this cycle only
    add(1'b0, 10'h0FF, 9'h100, 1'b0, 1'b1);
    // compare boundary: equal and max random never hit
    for (int i = 0; i < 12; i++)
      add(1'b1, 10'h100, 9'h100, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      add(1'b1, 10'h3FF, 9'h100, 1'b0, 1'b0);
    // just-below random hits at tick b27, press in b28
    for (int i = 0; i < 4; i++)
      add(1'b1, 10'h0FF, 9'h100, 1'b0, 1'b0);
    // enable dropped during the press cycle
    add(1'b0, 10'h0FF, 9'h100, 1'b1, 1'b0);
    // re-enable: press 4 cycles later, no residual cooldown
    for (int i = 0; i < 6; i++)
      add(1'b1, 10'h0FF, 9'h100, (i == 4), (i == 5));

    reset        = 1'b1;
    ia.enable    = 1'b0;
    ia.rand_in   = '0;
    ia.threshold = '0;
    ib.enable    = 1'b0;
    ib.rand_in   = '0;
    ib.threshold = 9'h1FF;

    repeat (2) begin
      step();
      chk("reset_press", ia.press, 1'b0);
      chk("reset_cool", ia.cooling, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_press", ia.press, 1'b0);
      chk("idle_cool", ia.cooling, 1'b0);
      chk("idle_press_b", ib.press, 1'b0);
    end

    ia.enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("never_fire", ia.press, 1'b0);
    end

    foreach (vecs[i]) begin
      ia.enable    = vecs[i].en;
      ia.rand_in   = vecs[i].rnd;
      ia.threshold = vecs[i].thr;
      chk($sformatf("vec%0d_press", i), ia.press, vecs[i].exp_press);
      chk($sformatf("vec%0d_cool", i), ia.cooling, vecs[i].exp_cool);
      step();
    end

    // COOLDOWN=0 with a constant hit: a press every 4 cycles
    ib.enable = 1'b1;
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("cd0_press%0d", i), ib.press,
          (i > 0) && (i % 4 == 0));
      chk($sformatf("cd0_cool%0d", i), ib.cooling, 1'b0);
      step();
    end

    // reset landing on a live pulse
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ia.press) seen = 1'b1;
      else step();
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_reset_wait: got no press, expected one within 40 cycles");
    end
    reset = 1'b1;
    step();
    chk("mid_reset_press", ia.press, 1'b0);
    chk("mid_reset_cool", ia.cooling, 1'b0);
    chk("mid_reset_press_b", ib.press, 1'b0);
    reset     = 1'b0;
    ia.enable = 1'b0;
    ib.enable = 1'b0;
    step();
    chk("post_reset_press", ia.press, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
